// File: rtl/axi_lite_burst_master_pkg.sv
// Shared definitions for the burst master: field widths, channel payload
// layouts (AR/AW/R/B bit slices) and the controller state encoding.
package axi_lite_burst_master_pkg;

    localparam int unsigned ADDR_W        = 8;
    localparam int unsigned LEN_W         = 4;
    localparam int unsigned ID_W          = 4;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned DEF_BUF_DEPTH = 16;

    localparam int unsigned AR_W = ADDR_W + LEN_W + ID_W;  // {addr, len, id}
    localparam int unsigned AW_W = ADDR_W + ID_W;          // {addr, id}
    localparam int unsigned R_W  = DATA_W + 1;             // {data, err}
    localparam int unsigned B_W  = ID_W + 1;               // {err, id}

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } ar_payload_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
    } aw_payload_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } r_payload_t;

    typedef struct packed {
        logic            err;
        logic [ID_W-1:0] id;
    } b_payload_t;

endpackage

// File: rtl/axi_lite_burst_master_if.sv
// Burst bus between master and slave: AR/R read channels, AW/W/B write
// channels. Modports: master (drives valids/payloads on request channels,
// readies on response channels) and slave (the mirror).
interface axi_lite_burst_master_if;
    import axi_lite_burst_master_pkg::*;

    logic            ARVALID;
    logic            ARREADY;
    logic [AR_W-1:0] AR_PAYLOAD;

    logic            RVALID;
    logic            RREADY;
    logic            RLAST;
    logic [R_W-1:0]  RDATA;

    logic            AWVALID;
    logic            AWREADY;
    logic [AW_W-1:0] AW_PAYLOAD;

    logic              WVALID;
    logic              WREADY;
    logic              WLAST;
    logic [DATA_W-1:0] WDATA;

    logic           BVALID;
    logic           BREADY;
    logic [B_W-1:0] BRESP;

    modport master (
        output ARVALID, AR_PAYLOAD, RREADY,
        output AWVALID, AW_PAYLOAD, WVALID, WLAST, WDATA, BREADY,
        input  ARREADY, RVALID, RLAST, RDATA,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  ARVALID, AR_PAYLOAD, RREADY,
        input  AWVALID, AW_PAYLOAD, WVALID, WLAST, WDATA, BREADY,
        output ARREADY, RVALID, RLAST, RDATA,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_lite_burst_master_burst_buf.sv
// Burst staging buffer: DEPTH x WIDTH, one synchronous write port and one
// combinational read port. Contents are not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module axi_lite_burst_master_burst_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/axi_lite_burst_master.sv
// Burst bus initiator: takes one host command (read/write, base address,
// len, id), runs the AR/R or AW/W/B handshakes, stages data in local
// buffers and reports completion via done/done_err/done_id.
// Ports: clk, rst (async, active-high); cmd_* host command; wbuf_* host
// write port into the write buffer; rbuf_addr/rbuf_dout host read port of
// the read buffer (combinational); done/done_err/done_id completion; bus
// (master modport of axi_lite_burst_master_if).
// Optional: define MASTER_TIMEOUT_EN to abort a stalled burst after 1000
// cycles without any handshake (completes with done_err=1).
module axi_lite_burst_master
    import axi_lite_burst_master_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH  // must be >= 2**LEN_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [LEN_W-1:0]             cmd_len,
    input  logic [ID_W-1:0]              cmd_id,
    input  logic                         wbuf_we,
    input  logic [$clog2(BUF_DEPTH)-1:0] wbuf_addr,
    input  logic [DATA_W-1:0]            wbuf_din,
    input  logic [$clog2(BUF_DEPTH)-1:0] rbuf_addr,
    output logic [DATA_W-1:0]            rbuf_dout,
    output logic                         done,
    output logic                         done_err,
    output logic [ID_W-1:0]              done_id,
    axi_lite_burst_master_if.master      bus
);
    localparam int unsigned BUF_AW = $clog2(BUF_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              err_q, err_d;

    logic              rbuf_we_c;
    logic              to_c;
    logic [DATA_W-1:0] wbuf_rd_c;
    r_payload_t        rd_c;
    b_payload_t        bresp_c;

    assign rd_c    = r_payload_t'(bus.RDATA);
    assign bresp_c = b_payload_t'(bus.BRESP);

`ifdef MASTER_TIMEOUT_EN
    // Watchdog: counts busy cycles since the last handshake.
    localparam int unsigned    WD_W    = 16;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(999);

    logic [WD_W-1:0] wd_q;
    logic            busy_c, hs_c;

    always_comb begin
        busy_c = (state_q == ST_AR) || (state_q == ST_R) || (state_q == ST_AW) ||
                 (state_q == ST_W)  || (state_q == ST_B);
        hs_c   = ((state_q == ST_AR) && bus.ARREADY) ||
                 ((state_q == ST_R)  && bus.RVALID)  ||
                 ((state_q == ST_AW) && bus.AWREADY) ||
                 ((state_q == ST_W)  && bus.WREADY)  ||
                 ((state_q == ST_B)  && bus.BVALID);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wd_q <= '0;
        else if (!busy_c || hs_c) wd_q <= '0;
        else                      wd_q <= wd_q + 1'b1;
    end

    // Fires on the cycle the count reaches its limit.
    assign to_c = busy_c && !hs_c && (wd_q == WD_LAST);
`else
    assign to_c = 1'b0;
`endif

    // State and burst context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        id_d      = id_q;
        beat_d    = beat_q;
        err_d     = err_q;
        rbuf_we_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AR: if (bus.ARREADY) state_d = ST_R;
            ST_R: begin
                if (bus.RVALID) begin
                    // Beats beyond len are flagged and dropped, not stored.
                    rbuf_we_c = (beat_q <= len_q);
                    err_d     = err_q | rd_c.err | (beat_q > len_q) |
                                (bus.RLAST && (beat_q != len_q));
                    if (beat_q != '1) beat_d = beat_q + 1'b1;
                    if (bus.RLAST)    state_d = ST_DONE;
                end
            end
            ST_AW: if (bus.AWREADY) state_d = ST_W;
            ST_W: begin
                if (bus.WREADY) begin
                    if (beat_q == len_q) state_d = ST_B;
                    else                 beat_d  = beat_q + 1'b1;
                end
            end
            ST_B: begin
                if (bus.BVALID) begin
                    err_d   = err_q | bresp_c.err | (bresp_c.id != id_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (to_c) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
        end
    end

    axi_lite_burst_master_burst_buf #(.DEPTH(BUF_DEPTH), .WIDTH(DATA_W)) u_wbuf (
        .clk   (clk),
        .we    (wbuf_we),
        .waddr (wbuf_addr),
        .wdata (wbuf_din),
        .raddr (BUF_AW'(beat_q)),
        .rdata (wbuf_rd_c)
    );

    axi_lite_burst_master_burst_buf #(.DEPTH(BUF_DEPTH), .WIDTH(DATA_W)) u_rbuf (
        .clk   (clk),
        .we    (rbuf_we_c),
        .waddr (BUF_AW'(beat_q)),
        .wdata (rd_c.data),
        .raddr (rbuf_addr),
        .rdata (rbuf_dout)
    );

    // Outputs decode the state register, so async reset clears them at once.
    assign cmd_ready      = (state_q == ST_IDLE);
    assign bus.ARVALID    = (state_q == ST_AR);
    assign bus.AR_PAYLOAD = ar_payload_t'{addr: addr_q, len: len_q, id: id_q};
    assign bus.RREADY     = (state_q == ST_R);
    assign bus.AWVALID    = (state_q == ST_AW);
    assign bus.AW_PAYLOAD = aw_payload_t'{addr: addr_q, id: id_q};
    assign bus.WVALID     = (state_q == ST_W);
    assign bus.WLAST      = (state_q == ST_W) && (beat_q == len_q);
    assign bus.WDATA      = (state_q == ST_W) ? wbuf_rd_c : '0;
    assign bus.BREADY     = (state_q == ST_B);
    assign done           = (state_q == ST_DONE);
    assign done_err       = (state_q == ST_DONE) && err_q;
    assign done_id        = (state_q == ST_DONE) ? id_q : '0;
endmodule

// File: tb/tb_axi_lite_burst_master.sv
// Self-checking bench for axi_lite_burst_master: directed bursts with a
// scoreboard of expected W beats and completions checked by bus monitors.
module tb_axi_lite_burst_master;
    import axi_lite_burst_master_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len, cmd_id;
    logic       wbuf_we;
    logic [3:0] wbuf_addr, rbuf_addr;
    logic [7:0] wbuf_din, rbuf_dout;
    logic       done, done_err;
    logic [3:0] done_id;

    axi_lite_burst_master_if bus();

    axi_lite_burst_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_id    (cmd_id),
        .wbuf_we   (wbuf_we),
        .wbuf_addr (wbuf_addr),
        .wbuf_din  (wbuf_din),
        .rbuf_addr (rbuf_addr),
        .rbuf_dout (rbuf_dout),
        .done      (done),
        .done_err  (done_err),
        .done_id   (done_id),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [8:0]  w_exp[$];   // {wlast, wdata}
    logic [4:0]  d_exp[$];   // {done_err, done_id}
    logic        wr_pat[$];  // WREADY per W cycle, 1 once empty
    logic [15:0] ar_exp;
    logic [11:0] aw_exp;
    logic [7:0]  wb_tab[16];
    logic [8:0]  rd_tab[16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus monitors, sampled mid-cycle.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_w     = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.ARVALID) begin
                check_eq("ar_payload", 32'(bus.AR_PAYLOAD), 32'(ar_exp));
                check_eq("ar_r_overlap", 32'(bus.RREADY), 32'd0);
            end
            if (bus.AWVALID) check_eq("aw_payload", 32'(bus.AW_PAYLOAD), 32'(aw_exp));
            if (bus.WVALID) begin
                if (prev_stall) check_eq("w_hold", 32'({bus.WLAST, bus.WDATA}), 32'(prev_w));
                if (bus.WREADY) begin
                    check_eq("w_beat_expected", 32'(w_exp.size() != 0), 32'd1);
                    if (w_exp.size() != 0)
                        check_eq("w_beat", 32'({bus.WLAST, bus.WDATA}), 32'(w_exp.pop_front()));
                end
            end
            prev_stall = bus.WVALID && !bus.WREADY;
            prev_w     = {bus.WLAST, bus.WDATA};
            if (done) begin
                done_cnt++;
                check_eq("done_expected", 32'(d_exp.size() != 0), 32'd1);
                if (d_exp.size() != 0)
                    check_eq("done_status", 32'({done_err, done_id}), 32'(d_exp.pop_front()));
            end
        end
    end

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [3:0] len,
                         input logic [3:0] id);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_id    = id;
        step();
        cmd_valid = 1'b0;
        check_eq("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    endtask

    task automatic load_wbuf(input int nb);
        for (int i = 0; i < nb; i++) begin
            wbuf_we   = 1'b1;
            wbuf_addr = 4'(i);
            wbuf_din  = wb_tab[i];
            step();
        end
        wbuf_we = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                               input int aw_delay, input logic [4:0] bresp, input logic exp_err);
        int n;
        int d0;
        load_wbuf(int'(len) + 1);
        for (int i = 0; i <= int'(len); i++) w_exp.push_back({(i == int'(len)), wb_tab[i]});
        d_exp.push_back({exp_err, id});
        aw_exp = {addr, id};
        d0     = done_cnt;
        issue(1'b1, addr, len, id);
        check_eq("aw_latency", 32'(bus.AWVALID), 32'd1);
        repeat (aw_delay) step();
        check_eq("aw_hold", 32'(bus.AWVALID), 32'd1);
        bus.AWREADY = 1'b1;
        step();
        bus.AWREADY = 1'b0;
        check_eq("w_start", 32'(bus.WVALID), 32'd1);
        check_eq("aw_drop", 32'(bus.AWVALID), 32'd0);
        n = 0;
        while (bus.WVALID && n < 50) begin
            bus.WREADY = (wr_pat.size() != 0) ? wr_pat.pop_front() : 1'b1;
            step();
            n++;
        end
        bus.WREADY = 1'b0;
        check_eq("w_beats_left", 32'(w_exp.size()), 32'd0);
        check_eq("w_drop", 32'(bus.WVALID), 32'd0);
        check_eq("b_ready", 32'(bus.BREADY), 32'd1);
        bus.BVALID = 1'b1;
        bus.BRESP  = bresp;
        step();
        bus.BVALID = 1'b0;
        check_eq("done_latency", 32'(done), 32'd1);
        step();
        check_eq("done_count", 32'(done_cnt - d0), 32'd1);
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                              input int nbeats, input logic exp_err);
        int d0;
        d_exp.push_back({exp_err, id});
        ar_exp = {addr, len, id};
        d0     = done_cnt;
        issue(1'b0, addr, len, id);
        check_eq("ar_latency", 32'(bus.ARVALID), 32'd1);
        check_eq("r_before_ar", 32'(bus.RREADY), 32'd0);
        bus.ARREADY = 1'b1;
        step();
        bus.ARREADY = 1'b0;
        check_eq("r_ready", 32'(bus.RREADY), 32'd1);
        check_eq("ar_drop", 32'(bus.ARVALID), 32'd0);
        for (int i = 0; i < nbeats; i++) begin
            bus.RVALID = 1'b1;
            bus.RDATA  = rd_tab[i];
            bus.RLAST  = (i == nbeats - 1);
            step();
        end
        bus.RVALID = 1'b0;
        bus.RLAST  = 1'b0;
        check_eq("done_latency", 32'(done), 32'd1);
        step();
        check_eq("done_count", 32'(done_cnt - d0), 32'd1);
        for (int i = 0; i < nbeats && i <= int'(len); i++) begin
            rbuf_addr = 4'(i);
            #1;
            check_eq("rbuf_data", 32'(rbuf_dout), 32'(rd_tab[i][8:1]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        int d0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wbuf_we = 1'b0; wbuf_addr = '0; wbuf_din = '0; rbuf_addr = '0;
        bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RDATA = '0;
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = '0;
        ar_exp = '0;
        aw_exp = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_valids", 32'({bus.ARVALID, bus.AWVALID, bus.WVALID, bus.WLAST}), 32'd0);
        check_eq("rst_readies", 32'({bus.RREADY, bus.BREADY}), 32'd0);
        check_eq("rst_done", 32'({done, done_err, done_id}), 32'd0);
        rst = 1'b0;
        step();

        // Write len=3, AWREADY after 2 cycles, clean response.
        wb_tab[0] = 8'hA1; wb_tab[1] = 8'hB2; wb_tab[2] = 8'hC3; wb_tab[3] = 8'hD4;
        write_burst(8'h10, 4'd3, 4'd5, 2, 5'h05, 1'b0);

        // Read len=2, clean.
        rd_tab[0] = {8'h11, 1'b0}; rd_tab[1] = {8'h22, 1'b0}; rd_tab[2] = {8'h33, 1'b0};
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_len = 4'd2; cmd_id = 4'd3;
        cmd_valid = 1'b0;
        read_burst(8'h20, 4'd2, 4'd3, 3, 1'b0);
        check_eq("ar_payload_last", 32'(bus.AR_PAYLOAD), 32'h2023);

        // Read len=1 with error flagged on the second beat.
        rd_tab[0] = {8'h5A, 1'b0}; rd_tab[1] = 9'h001;
        read_burst(8'h30, 4'd1, 4'd7, 2, 1'b1);

        // Read len=3 terminated early by RLAST on beat 1.
        rd_tab[0] = {8'h66, 1'b0}; rd_tab[1] = {8'h77, 1'b0};
        read_burst(8'h34, 4'd3, 4'd9, 2, 1'b1);

        // Write len=2 with WREADY stalls and a mismatched response ID.
        wb_tab[0] = 8'h3C; wb_tab[1] = 8'h4D; wb_tab[2] = 8'h5E;
        wr_pat.push_back(1'b1); wr_pat.push_back(1'b0); wr_pat.push_back(1'b0);
        wr_pat.push_back(1'b1); wr_pat.push_back(1'b1);
        write_burst(8'h40, 4'd2, 4'd5, 0, 5'h06, 1'b1);

        // Reset in the middle of a write burst, on beat 2.
        wb_tab[0] = 8'h01; wb_tab[1] = 8'h02; wb_tab[2] = 8'h03; wb_tab[3] = 8'h04;
        load_wbuf(4);
        for (int i = 0; i < 4; i++) w_exp.push_back({(i == 3), wb_tab[i]});
        aw_exp = {8'h48, 4'd2};
        issue(1'b1, 8'h48, 4'd3, 4'd2);
        bus.AWREADY = 1'b1;
        step();
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b1;
        step();
        step();
        check_eq("w_beat2_data", 32'(bus.WDATA), 32'h03);
        bus.WREADY = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_wvalid", 32'(bus.WVALID), 32'd0);
        check_eq("rst_mid_bready", 32'(bus.BREADY), 32'd0);
        check_eq("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        w_exp.delete();
        d0 = done_cnt;
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
        check_eq("no_partial_done", 32'(done_cnt - d0), 32'd0);
        rd_tab[0] = {8'h9A, 1'b0}; rd_tab[1] = {8'hBC, 1'b0}; rd_tab[2] = {8'hDE, 1'b0};
        read_burst(8'h50, 4'd2, 4'd4, 3, 1'b0);

`ifdef MASTER_TIMEOUT_EN
        // AWREADY never arrives: watchdog aborts with an error.
        d_exp.push_back({1'b1, 4'd1});
        aw_exp = {8'h60, 4'd1};
        issue(1'b1, 8'h60, 4'd0, 4'd1);
        n = 0;
        while (!done && n < 1100) begin
            step();
            n++;
        end
        check_eq("timeout_cycles", 32'(n), 32'd1000);
        check_eq("timeout_done", 32'(done), 32'd1);
        check_eq("timeout_awvalid", 32'(bus.AWVALID), 32'd0);
        step();
        check_eq("timeout_idle", 32'(cmd_ready), 32'd1);
`else
        n = 0;
`endif

        check_eq("done_outstanding", 32'(d_exp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_burst_master.md
Name: axi_lite_burst_master

Overview:
Initiator for the team's packed burst bus (AR/R/AW/W/B channels, 8-bit address, 4-bit length/ID, 8-bit data).
- Accepts one host command at a time (read or write, base address, length, ID).
- Drives the request, data and response handshakes to a slave.
- Stages write data in, and read data out of, local 16-entry burst buffers.
- Reports completion with an error/ID status.

Parameters:
- BUF_DEPTH, 16: burst buffer entries; must be >= 2**LEN_W.
- LEN_W, 4: burst length field width; beats = len+1.
- ID_W, 4: transaction ID width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  master idle, can accept a command
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  8  base address
- cmd_len  in  4  beats minus one
- cmd_id  in  4  transaction ID
- wbuf_we  in  1  host write strobe into the write buffer
- wbuf_addr  in  4  write buffer index
- wbuf_din  in  8  write buffer data
- rbuf_addr  in  4  read buffer index
- rbuf_dout  out  8  read buffer data, combinational from rbuf_addr
- done  out  1  one-cycle completion pulse
- done_err  out  1  error status, valid with done
- done_id  out  4  ID of the completed burst, valid with done
- ARVALID  out  1  read address valid
- ARREADY  in  1  read address ready
- AR_PAYLOAD  out  16  {addr[15:8], len[7:4], id[3:0]}
- RVALID  in  1  read beat valid
- RREADY  out  1  read beat ready
- RLAST  in  1  final read beat
- RDATA  in  9  {data[8:1], err[0]}
- AWVALID  out  1  write address valid
- AWREADY  in  1  write address ready
- AW_PAYLOAD  out  12  {addr[11:4], id[3:0]}
- WVALID  out  1  write beat valid
- WREADY  in  1  write beat ready
- WLAST  out  1  final write beat
- WDATA  out  8  write beat data
- BVALID  in  1  write response valid
- BREADY  out  1  write response ready
- BRESP  in  5  {err[4], id[3:0]}

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; state IDLE; beat counter 0; error flag 0. Buffer contents retained, not cleared.
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/id/write, clear error flag and beat counter, go to AR (read) or AW (write). cmd_ready drops the next cycle.
- AR: ARVALID=1, AR_PAYLOAD stable. When ARVALID&ARREADY, go to R the next cycle; ARVALID and RREADY are never high together.
- R: RREADY=1. On each RVALID&RREADY:
  - if beat <= len, store RDATA[8:1] at rbuf[beat];
  - OR RDATA[0] into the error flag;
  - beat++ (saturates at 15).
  - On RLAST, go to DONE.
  - Error flag also set if RLAST arrives with beat != len, or a beat arrives with beat > len (data discarded).
- AW: AWVALID=1 until AWVALID&AWREADY, then go to W.
- W: WVALID=1, WDATA=wbuf[beat], WLAST=(beat==len).
  - Each WVALID&WREADY advances beat.
  - When the accepted beat had WLAST, drop WVALID/WLAST and go to B.
  - WDATA/WLAST hold stable while WREADY=0.
- B: BREADY=1. On BVALID, error flag |= BRESP[4] | (BRESP[3:0] != id); go to DONE.
- DONE: done=1 for exactly one cycle, done_err=flag, done_id=id; return to IDLE.
- Latency: command to ARVALID/AWVALID is 1 cycle. Last handshake to done is 1 cycle.
- Host interface:
  - wbuf_we is accepted in any state; writing while in W is the host's error and may corrupt beats.
  - rbuf reads are valid after done.
- Address: only the base address is sent; the slave increments per beat. Address wrap is the slave's concern.
- Reset mid-burst: immediate return to IDLE, all bus outputs low the same cycle; no partial done.

Optional Feature:
- MASTER_TIMEOUT_EN defined: a 16-bit watchdog counts cycles in AR/R/AW/W/B without a handshake and is cleared by any handshake. On reaching 1000, go to DONE with done_err=1 and drop all valids/readies.
- Undefined: no counter; the master waits forever.

Decomposition:
- Package master_pkg: state enum, payload field widths/offsets (AR/AW/R/BRESP bit slices), LEN_W/ID_W constants.
- One natural sub-module burst_buf: BUF_DEPTHx8, one synchronous write port, one combinational read port. Instantiated twice (wbuf, rbuf).

Test Plan:
- Write burst, addr=0x10, len=3, id=5, wbuf={A1,B2,C3,D4}; slave AWREADY after 2 cycles, WREADY=1, BRESP=0x05 -> 4 W beats A1..D4, WLAST on 4th only, done=1 one cycle, done_err=0, done_id=5.
- Read burst, addr=0x20, len=2, id=3; R beats {0x11,0x22,0x33}, err=0, RLAST on 3rd -> rbuf[0..2]=11,22,33, done_err=0, AR_PAYLOAD=0x2023.
- Read len=1, 2nd beat RDATA=0x001 (err) -> done_err=1. Separately, RLAST on beat 1 of len=3 -> done_err=1.
- Write len=2 with WREADY toggling 1,0,0,1,1 -> WDATA/WLAST held during stalls, exactly 3 accepted beats. Then BRESP=0x06 with id=5 -> done_err=1.
- rst asserted during W beat 2 -> WVALID/BREADY low immediately, cmd_ready=1, no done. Next read command completes normally.
- MASTER_TIMEOUT_EN: AWREADY held 0 -> done with done_err=1 after 1000 cycles, AWVALID low after.
